reg_file_wr_arb: RTL

- Shares the single register-file write port between two writeback sources.
  - Port 0: ALU/EX writeback.
  - Port 1: load/mult-div writeback.
- Each source has a small per-port FIFO; a round-robin arbiter drains one entry per cycle into the register file write interface.
- Provides a pending-write lookup so decode can stall on registers whose writes are still buffered.
- Sits between the writeback stage and the register file in the decode stage.

---
 rtl/reg_file_wr_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_file_wr_arb.sv
// Register-file write-port sharer: two writeback FIFOs drained round-robin into
// the single write port, plus a pending-write lookup that decode stalls on.
package reg_file_pkg;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } reg_file_wr_req_pkt_t;
endpackage

module reg_file_wr_arb
    import reg_file_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [1:0]                 wb_req_vld,
    input  reg_file_wr_req_pkt_t [1:0] wb_req_pkt,
    output logic [1:0]                 wb_req_rdy,
    output logic                       reg_file_wr_req_vld,
    output reg_file_wr_req_pkt_t       reg_file_wr_req_pkt,
    input  logic [1:0][4:0]            pend_chk_addr,
    output logic [1:0]                 pend_hit
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    reg_file_wr_req_pkt_t mem_q     [2][DEPTH];
    logic [DEPTH-1:0]     ent_vld_q [2];
    ptr_t                 wr_ptr_q  [2];
    ptr_t                 rd_ptr_q  [2];
    cnt_t                 count_q   [2];
    logic                 last_gnt_q;

    logic [1:0] non_empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic       gnt_sel;

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        gnt_sel             = 1'b0;
        pop                 = '0;
        reg_file_wr_req_pkt = '0;
        for (int i = 0; i < 2; i++) begin
            non_empty[i]  = (count_q[i] != '0);
            wb_req_rdy[i] = (count_q[i] != cnt_t'(DEPTH));
            // addr 0 completes the handshake but is never buffered
            push[i]       = wb_req_vld[i] && wb_req_rdy[i] && (wb_req_pkt[i].addr != '0);
        end
        if (&non_empty)
            gnt_sel = ~last_gnt_q;
        else if (non_empty[1])
            gnt_sel = 1'b1;
        reg_file_wr_req_vld = |non_empty;
        if (reg_file_wr_req_vld) begin
            pop[gnt_sel]        = 1'b1;
            reg_file_wr_req_pkt = mem_q[gnt_sel][rd_ptr_q[gnt_sel]];
        end
    end

    // The entry granted this cycle is forwarded by the register file, so it is not pending.
    always_comb begin
        pend_hit = '0;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (ent_vld_q[i][k] && (mem_q[i][k].addr == pend_chk_addr[j]) &&
                        !(pop[i] && (rd_ptr_q[i] == ptr_t'(k))))
                        pend_hit[j] = 1'b1;
                end
            end
            if (pend_chk_addr[j] == '0)
                pend_hit[j] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                ent_vld_q[i] <= '0;
                wr_ptr_q[i]  <= '0;
                rd_ptr_q[i]  <= '0;
                count_q[i]   <= '0;
            end
            last_gnt_q <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    ent_vld_q[i][wr_ptr_q[i]] <= 1'b1;
                    wr_ptr_q[i]               <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    ent_vld_q[i][rd_ptr_q[i]] <= 1'b0;
                    rd_ptr_q[i]               <= rd_ptr_q[i] + 1'b1;
                end
                count_q[i] <= count_q[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
            end
            if (reg_file_wr_req_vld)
                last_gnt_q <= gnt_sel;
        end
    end

    // NOTE: the payload array is not reset; ent_vld_q and count_q gate every
    // use of it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i])
                mem_q[i][wr_ptr_q[i]] <= wb_req_pkt[i];
        end
    end
endmodule
